// File: rtl/forward_scoreboard_if.sv
// Operand-forwarding scoreboard bus: issue-slot descriptor, operand
// lookups and the forwarding/stall results returned to the pipeline.
interface forward_scoreboard_if #(
  parameter int NUM_RD = 2,
  parameter int STAGES = 3,
  parameter int AW     = 5
);
  localparam int SW = $clog2(STAGES + 1);

  logic                 hold;
  logic                 flush;
  logic                 iss_valid;
  logic                 iss_regwrite;
  logic                 iss_load;
  logic [AW-1:0]        iss_rd;
  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD-1:0]    rd_used;
  logic                 cnt_clr;
  logic [NUM_RD*SW-1:0] fwd_sel;
  logic                 stall;
  logic [15:0]          stall_cnt;

  // Pipeline control / issue side drives the lookups and reads the verdict.
  modport master (
    output hold, flush, iss_valid, iss_regwrite, iss_load, iss_rd,
           rd_addr, rd_used, cnt_clr,
    input  fwd_sel, stall, stall_cnt
  );

  // Scoreboard consumes the lookups and produces the verdict.
  modport slave (
    input  hold, flush, iss_valid, iss_regwrite, iss_load, iss_rd,
           rd_addr, rd_used, cnt_clr,
    output fwd_sel, stall, stall_cnt
  );
endinterface

// File: rtl/forward_scoreboard.sv
// Forwarding scoreboard: tracks destination registers of the last STAGES
// issued writers, selects the youngest ready producer per operand port and
// raises a load-use stall when the youngest producer is a load not yet ready.
// LOAD_RDY must lie in 1..STAGES; LOAD_RDY=1 makes loads forwardable at once.
module forward_scoreboard #(
  parameter int NUM_RD   = 2,
  parameter int STAGES   = 3,
  parameter int LOAD_RDY = 2,
  parameter int AW       = 5
) (
  input  logic              clk,
  input  logic              reset,
  forward_scoreboard_if.slave bus
);
  localparam int SW = $clog2(STAGES + 1);

  // Index 0 holds stage 1 (youngest).
  logic [STAGES-1:0]    vld_q, vld_d;
  logic [STAGES-1:0]    ld_q, ld_d;
  logic [AW-1:0]        rd_q [STAGES];
  logic [AW-1:0]        rd_d [STAGES];
  logic [15:0]          cnt_q, cnt_d;
  logic [NUM_RD*SW-1:0] fwd_sel;
  logic [NUM_RD-1:0]    haz;
  logic                 stall;
  logic                 capture;

  // Per-port lookup: first valid match from the youngest stage wins, even when
  // that producer is a load that cannot forward yet (then it is a hazard).
  always_comb begin
    logic hit;
    fwd_sel = '0;
    haz     = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      hit = 1'b0;
      if (bus.rd_used[p] && (bus.rd_addr[p*AW +: AW] != '0)) begin
        for (int k = 0; k < STAGES; k++) begin
          if (!hit && vld_q[k] && (rd_q[k] == bus.rd_addr[p*AW +: AW])) begin
            hit = 1'b1;
            if (!ld_q[k] || ((k + 1) >= LOAD_RDY)) begin
              fwd_sel[p*SW +: SW] = SW'(k + 1);
            end else begin
              haz[p] = 1'b1;
            end
          end
        end
      end
    end
  end

  // A killed issue slot needs no operands, so flush masks the stall; a stalled
  // or killed slot enters the tracker as a bubble.
  always_comb begin
    stall   = (|haz) & ~bus.flush;
    capture = bus.iss_valid & bus.iss_regwrite & (bus.iss_rd != '0) &
              ~bus.flush & ~stall;
  end

  // Next-state: shift the tracker one stage unless frozen; saturating counter
  // with clear taking priority.
  always_comb begin
    vld_d = vld_q;
    ld_d  = ld_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (!bus.hold) begin
      vld_d[0] = capture;
      ld_d[0]  = bus.iss_load;
      rd_d[0]  = bus.iss_rd;
      for (int k = 1; k < STAGES; k++) begin
        vld_d[k] = vld_q[k-1];
        ld_d[k]  = ld_q[k-1];
        rd_d[k]  = rd_q[k-1];
      end
    end
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (stall && !bus.hold && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Control state: valid bits and stall counter, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry payload: meaningful only while the matching valid bit is set.
  always_ff @(posedge clk) begin
    ld_q <= ld_d;
    rd_q <= rd_d;
  end

  assign bus.fwd_sel   = fwd_sel;
  assign bus.stall     = stall;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_forward_scoreboard.sv
// Bench for forward_scoreboard (STAGES=3, LOAD_RDY=2, NUM_RD=2, AW=5).
module tb_forward_scoreboard;

  typedef struct {
    logic       iv, rw, ld;
    logic [4:0] rd, a0, a1;
    logic [1:0] used;
    logic       fl, hd, clr;
    logic [3:0] f;
    logic       s;
    logic [15:0] c;
  } step_t;

  typedef struct {
    logic [3:0]  f;
    logic        s;
    logic [15:0] c;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  exp_t sbq[$];

  forward_scoreboard_if #(.NUM_RD(2), .STAGES(3), .AW(5)) bus ();

  forward_scoreboard #(.NUM_RD(2), .STAGES(3), .LOAD_RDY(2), .AW(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic iv, input logic rw, input logic ld,
                       input logic [4:0] rd, input logic [4:0] a0,
                       input logic [4:0] a1, input logic [1:0] used,
                       input logic fl, input logic hd, input logic clr);
    bus.iss_valid    = iv;
    bus.iss_regwrite = rw;
    bus.iss_load     = ld;
    bus.iss_rd       = rd;
    bus.rd_addr      = {a1, a0};
    bus.rd_used      = used;
    bus.flush        = fl;
    bus.hold         = hd;
    bus.cnt_clr      = clr;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    sbq.push_back(exp_t'{4'h0, 1'b0, 16'd0});
    #3;
    e = sbq.pop_front();
    checks++; if (bus.fwd_sel !== e.f) begin errors++; $display("FAIL reset_init fwd_sel got=%h exp=%h", bus.fwd_sel, e.f); end
    checks++; if (bus.stall !== e.s) begin errors++; $display("FAIL reset_init stall got=%b exp=%b", bus.stall, e.s); end
    checks++; if (bus.stall_cnt !== e.c) begin errors++; $display("FAIL reset_init stall_cnt got=%h exp=%h", bus.stall_cnt, e.c); end
    // Issue activity across an edge while reset is low must not be captured.
    drive(1, 1, 0, 5, 5, 0, 2'b01, 0, 0, 0);
    sbq.push_back(exp_t'{4'h0, 1'b0, 16'd0});
    @(negedge clk);
    e = sbq.pop_front();
    checks++; if (bus.fwd_sel !== e.f) begin errors++; $display("FAIL reset_hold fwd_sel got=%h exp=%h", bus.fwd_sel, e.f); end
    checks++; if (bus.stall_cnt !== e.c) begin errors++; $display("FAIL reset_hold stall_cnt got=%h exp=%h", bus.stall_cnt, e.c); end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_alu_chain();
    step_t tbl[$];
    step_t s;
    exp_t  e;
    tbl.push_back(step_t'{1, 1, 0, 5, 0, 0, 2'b00, 0, 0, 0, 4'h0, 0, 16'd0});
    tbl.push_back(step_t'{0, 0, 0, 0, 5, 0, 2'b01, 0, 0, 0, 4'h1, 0, 16'd0});
    tbl.push_back(step_t'{0, 0, 0, 0, 5, 0, 2'b01, 0, 0, 0, 4'h2, 0, 16'd0});
    tbl.push_back(step_t'{0, 0, 0, 0, 5, 0, 2'b01, 0, 0, 0, 4'h3, 0, 16'd0});
    tbl.push_back(step_t'{0, 0, 0, 0, 5, 0, 2'b01, 0, 0, 0, 4'h0, 0, 16'd0});
    for (int i = 0; i < tbl.size(); i++) begin
      s = tbl[i];
      drive(s.iv, s.rw, s.ld, s.rd, s.a0, s.a1, s.used, s.fl, s.hd, s.clr);
      sbq.push_back(exp_t'{s.f, s.s, s.c});
      @(negedge clk);
      e = sbq.pop_front();
      checks++; if (bus.fwd_sel !== e.f) begin errors++; $display("FAIL alu[%0d] fwd_sel got=%h exp=%h", i, bus.fwd_sel, e.f); end
      checks++; if (bus.stall !== e.s) begin errors++; $display("FAIL alu[%0d] stall got=%b exp=%b", i, bus.stall, e.s); end
      checks++; if (bus.stall_cnt !== e.c) begin errors++; $display("FAIL alu[%0d] stall_cnt got=%h exp=%h", i, bus.stall_cnt, e.c); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    step_t tbl[$];
    step_t s;
    exp_t  e;
    tbl.push_back(step_t'{1, 1, 1, 8, 0, 0, 2'b00, 0, 0, 0, 4'h0, 0, 16'd0});
    tbl.push_back(step_t'{1, 1, 0, 9, 0, 8, 2'b10, 0, 0, 0, 4'h0, 1, 16'd0});
    tbl.push_back(step_t'{1, 1, 0, 9, 9, 8, 2'b11, 0, 0, 0, 4'h8, 0, 16'd1});
    tbl.push_back(step_t'{0, 0, 0, 0, 9, 0, 2'b01, 0, 0, 0, 4'h1, 0, 16'd1});
    tbl.push_back(step_t'{1, 1, 1, 8, 0, 0, 2'b00, 0, 0, 0, 4'h0, 0, 16'd1});
    tbl.push_back(step_t'{1, 1, 0, 9, 0, 8, 2'b10, 1, 0, 0, 4'h0, 0, 16'd1});
    tbl.push_back(step_t'{0, 0, 0, 0, 9, 8, 2'b11, 0, 0, 0, 4'h8, 0, 16'd1});
    for (int i = 0; i < tbl.size(); i++) begin
      s = tbl[i];
      drive(s.iv, s.rw, s.ld, s.rd, s.a0, s.a1, s.used, s.fl, s.hd, s.clr);
      sbq.push_back(exp_t'{s.f, s.s, s.c});
      @(negedge clk);
      e = sbq.pop_front();
      checks++; if (bus.fwd_sel !== e.f) begin errors++; $display("FAIL load_use[%0d] fwd_sel got=%h exp=%h", i, bus.fwd_sel, e.f); end
      checks++; if (bus.stall !== e.s) begin errors++; $display("FAIL load_use[%0d] stall got=%b exp=%b", i, bus.stall, e.s); end
      checks++; if (bus.stall_cnt !== e.c) begin errors++; $display("FAIL load_use[%0d] stall_cnt got=%h exp=%h", i, bus.stall_cnt, e.c); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority_zero();
    step_t tbl[$];
    step_t s;
    exp_t  e;
    tbl.push_back(step_t'{1, 1, 0, 3, 0, 0, 2'b00, 0, 0, 0, 4'h0, 0, 16'd1});
    tbl.push_back(step_t'{1, 1, 0, 7, 0, 0, 2'b00, 0, 0, 0, 4'h0, 0, 16'd1});
    tbl.push_back(step_t'{1, 1, 0, 3, 0, 0, 2'b00, 0, 0, 0, 4'h0, 0, 16'd1});
    tbl.push_back(step_t'{1, 1, 0, 0, 3, 7, 2'b11, 0, 0, 0, 4'h9, 0, 16'd1});
    tbl.push_back(step_t'{0, 0, 0, 0, 3, 3, 2'b10, 0, 0, 0, 4'h8, 0, 16'd1});
    tbl.push_back(step_t'{0, 0, 0, 0, 0, 3, 2'b11, 0, 0, 0, 4'hC, 0, 16'd1});
    for (int i = 0; i < tbl.size(); i++) begin
      s = tbl[i];
      drive(s.iv, s.rw, s.ld, s.rd, s.a0, s.a1, s.used, s.fl, s.hd, s.clr);
      sbq.push_back(exp_t'{s.f, s.s, s.c});
      @(negedge clk);
      e = sbq.pop_front();
      checks++; if (bus.fwd_sel !== e.f) begin errors++; $display("FAIL prio[%0d] fwd_sel got=%h exp=%h", i, bus.fwd_sel, e.f); end
      checks++; if (bus.stall !== e.s) begin errors++; $display("FAIL prio[%0d] stall got=%b exp=%b", i, bus.stall, e.s); end
      checks++; if (bus.stall_cnt !== e.c) begin errors++; $display("FAIL prio[%0d] stall_cnt got=%h exp=%h", i, bus.stall_cnt, e.c); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hold();
    step_t tbl[$];
    step_t s;
    exp_t  e;
    tbl.push_back(step_t'{1, 1, 0, 10, 0, 0, 2'b00, 0, 0, 0, 4'h0, 0, 16'd1});
    tbl.push_back(step_t'{1, 1, 1, 10, 0, 0, 2'b00, 0, 0, 0, 4'h0, 0, 16'd1});
    tbl.push_back(step_t'{1, 1, 0, 11, 10, 0, 2'b01, 0, 1, 0, 4'h0, 1, 16'd1});
    tbl.push_back(step_t'{1, 1, 0, 11, 10, 0, 2'b01, 0, 1, 0, 4'h0, 1, 16'd1});
    tbl.push_back(step_t'{1, 1, 0, 11, 10, 0, 2'b01, 0, 0, 0, 4'h0, 1, 16'd1});
    tbl.push_back(step_t'{1, 1, 0, 11, 10, 11, 2'b11, 0, 0, 0, 4'h2, 0, 16'd2});
    tbl.push_back(step_t'{0, 0, 0, 0, 0, 11, 2'b10, 0, 0, 0, 4'h4, 0, 16'd2});
    for (int i = 0; i < tbl.size(); i++) begin
      s = tbl[i];
      drive(s.iv, s.rw, s.ld, s.rd, s.a0, s.a1, s.used, s.fl, s.hd, s.clr);
      sbq.push_back(exp_t'{s.f, s.s, s.c});
      @(negedge clk);
      e = sbq.pop_front();
      checks++; if (bus.fwd_sel !== e.f) begin errors++; $display("FAIL hold[%0d] fwd_sel got=%h exp=%h", i, bus.fwd_sel, e.f); end
      checks++; if (bus.stall !== e.s) begin errors++; $display("FAIL hold[%0d] stall got=%b exp=%b", i, bus.stall, e.s); end
      checks++; if (bus.stall_cnt !== e.c) begin errors++; $display("FAIL hold[%0d] stall_cnt got=%h exp=%h", i, bus.stall_cnt, e.c); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    step_t tbl[$];
    step_t s;
    exp_t  e;
    tbl.push_back(step_t'{1, 1, 0, 1, 0, 0, 2'b00, 0, 0, 0, 4'h0, 0, 16'd2});
    tbl.push_back(step_t'{1, 1, 0, 2, 0, 0, 2'b00, 0, 0, 0, 4'h0, 0, 16'd2});
    tbl.push_back(step_t'{1, 1, 1, 3, 0, 0, 2'b00, 0, 0, 0, 4'h0, 0, 16'd2});
    tbl.push_back(step_t'{0, 0, 0, 0, 3, 1, 2'b11, 0, 0, 0, 4'hC, 1, 16'd2});
    for (int i = 0; i < tbl.size(); i++) begin
      s = tbl[i];
      drive(s.iv, s.rw, s.ld, s.rd, s.a0, s.a1, s.used, s.fl, s.hd, s.clr);
      sbq.push_back(exp_t'{s.f, s.s, s.c});
      @(negedge clk);
      e = sbq.pop_front();
      checks++; if (bus.fwd_sel !== e.f) begin errors++; $display("FAIL rmid[%0d] fwd_sel got=%h exp=%h", i, bus.fwd_sel, e.f); end
      checks++; if (bus.stall !== e.s) begin errors++; $display("FAIL rmid[%0d] stall got=%b exp=%b", i, bus.stall, e.s); end
      checks++; if (bus.stall_cnt !== e.c) begin errors++; $display("FAIL rmid[%0d] stall_cnt got=%h exp=%h", i, bus.stall_cnt, e.c); end
      if (i < tbl.size() - 1) begin
        @(posedge clk); #1;
      end
    end
    // Three valid entries and a live stall: reset must clear outputs before the next edge.
    #2;
    reset = 1'b0;
    sbq.push_back(exp_t'{4'h0, 1'b0, 16'd0});
    #1;
    e = sbq.pop_front();
    checks++; if (bus.fwd_sel !== e.f) begin errors++; $display("FAIL rmid_async fwd_sel got=%h exp=%h", bus.fwd_sel, e.f); end
    checks++; if (bus.stall !== e.s) begin errors++; $display("FAIL rmid_async stall got=%b exp=%b", bus.stall, e.s); end
    checks++; if (bus.stall_cnt !== e.c) begin errors++; $display("FAIL rmid_async stall_cnt got=%h exp=%h", bus.stall_cnt, e.c); end
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1, 1, 0, 6, 0, 0, 2'b00, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 6, 0, 2'b01, 0, 0, 0);
    sbq.push_back(exp_t'{4'h1, 1'b0, 16'd0});
    @(negedge clk);
    e = sbq.pop_front();
    checks++; if (bus.fwd_sel !== e.f) begin errors++; $display("FAIL rmid_first_capture fwd_sel got=%h exp=%h", bus.fwd_sel, e.f); end
    checks++; if (bus.stall_cnt !== e.c) begin errors++; $display("FAIL rmid_first_capture stall_cnt got=%h exp=%h", bus.stall_cnt, e.c); end
    @(posedge clk); #1;
  endtask

  task automatic test_counter_sat();
    exp_t        e;
    logic        st;
    logic [3:0]  f;
    logic [15:0] exp_cnt;
    // Preload the counter near saturation while the pipeline is frozen.
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0);
    force dut.cnt_q = 16'hFFF0;
    @(posedge clk); #1;
    release dut.cnt_q;
    exp_cnt = 16'hFFF0;
    // A load to r8 re-issued every cycle with r8 read: stalls every other cycle.
    for (int n = 0; n < 44; n++) begin
      st = n[0];
      f  = (st || n == 0) ? 4'h0 : 4'h2;
      drive(1, 1, 1, 8, 8, 0, 2'b01, 0, 0, (n == 41));
      sbq.push_back(exp_t'{f, st, exp_cnt});
      @(negedge clk);
      e = sbq.pop_front();
      checks++; if (bus.fwd_sel !== e.f) begin errors++; $display("FAIL cnt[%0d] fwd_sel got=%h exp=%h", n, bus.fwd_sel, e.f); end
      checks++; if (bus.stall !== e.s) begin errors++; $display("FAIL cnt[%0d] stall got=%b exp=%b", n, bus.stall, e.s); end
      checks++; if (bus.stall_cnt !== e.c) begin errors++; $display("FAIL cnt[%0d] stall_cnt got=%h exp=%h", n, bus.stall_cnt, e.c); end
      if (n == 41) exp_cnt = 16'h0000;
      else if (st && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_priority_zero();
    test_hold();
    test_reset_mid();
    test_counter_sat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/forward_scoreboard.md
FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 Parameter NUM_RD, default 2: number of operand read ports checked per cycle.
REQ-002 Parameter STAGES, default 3: number of producer pipeline stages tracked after issue (stage 1 = youngest).
REQ-003 Parameter LOAD_RDY, default 2: first stage (1..STAGES) at which a load result becomes forwardable.
REQ-004 Parameter AW, default 5: register address width.
REQ-005 Localparam SW = $clog2(STAGES+1): forward-select width.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 hold  input  1  pipeline freeze: tracked state does not move.
REQ-009 flush  input  1  current issue slot is killed (enters as bubble).
REQ-010 iss_valid  input  1  instruction in issue slot.
REQ-011 iss_regwrite  input  1  issuing instruction writes a register.
REQ-012 iss_load  input  1  issuing instruction is a load.
REQ-013 iss_rd  input  AW  issuing instruction destination.
REQ-014 rd_addr  input  NUM_RD*AW  packed operand addresses, port p at [p*AW +: AW].
REQ-015 rd_used  input  NUM_RD  per-port operand-in-use flag.
REQ-016 cnt_clr  input  1  synchronous clear of stall counter.
REQ-017 fwd_sel  output  NUM_RD*SW  per-port source: 0 = register file, k = stage k result.
REQ-018 stall  output  1  load-use hazard: hold issue slot, insert bubble.
REQ-019 stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-020 State: STAGES entries, each {valid, rd, load}; outputs fwd_sel/stall are combinational from entries and rd_* inputs.
REQ-021 Entry captured only if iss_valid & iss_regwrite & iss_rd!=0 & !flush & !stall; otherwise a bubble (valid=0) enters stage 1.
REQ-022 When hold=0: stage 1 <= captured entry or bubble, stage k <= stage k-1 for k=2..STAGES, stage STAGES entry retires.
REQ-023 When hold=1: all entries retain value; stall_cnt does not change.
REQ-024 Latency: instruction issued in cycle t is visible in stage 1 at cycle t+1, stage k at t+k (absent hold).
REQ-025 Entry k is ready if valid & (!load | k >= LOAD_RDY).
REQ-026 Port p match: rd_used[p] & addr!=0 & the lowest-index (youngest) valid entry with rd==addr.
REQ-027 Matched & ready -> fwd_sel[p]=k; matched & not ready -> fwd_sel[p]=0 and port hazard; no match, addr=0 or rd_used=0 -> fwd_sel[p]=0.
REQ-028 Older entries with same rd are ignored when a younger match exists, even if the younger is not ready.
REQ-029 stall = OR of port hazards; stall asserted with flush=1 yields stall=0 (killed instruction needs no operands).
REQ-030 stall_cnt increments by 1 on cycles with stall & !hold, saturates at 16'hFFFF; cnt_clr has priority over increment and sets 0.
REQ-031 LOAD_RDY > STAGES is illegal; LOAD_RDY=1 means loads never stall.

Reset
REQ-032 reset low asynchronously invalidates all entries and clears stall_cnt; hence fwd_sel=0, stall=0 immediately.
REQ-033 Reset asserted mid-hazard drops stall in the same cycle; first capture occurs on the first rising edge with reset high.

Verification (STAGES=3, LOAD_RDY=2, NUM_RD=2)
REQ-034 ALU chain: issue rd=5 writer; next cycle rd_addr0=5 -> fwd_sel0=1; following cycle (bubble issued) -> fwd_sel0=2, then 3, then 0.
REQ-035 Load-use: issue load rd=8; next cycle rd_addr1=8 -> stall=1, fwd_sel1=0; next cycle -> stall=0, fwd_sel1=2, stall_cnt=1.
REQ-036 Priority/zero: writers rd=3 at stages 1 and 3 -> fwd_sel0=1; writer rd=0 issued -> never matched, fwd_sel=0.
REQ-037 Hold: during load-use stall assert hold=1 for 2 cycles -> entries frozen, stall stays 1, stall_cnt unchanged; release -> resolves next cycle.
REQ-038 Counter: force 65536 stall cycles -> stall_cnt=16'hFFFF and stays; cnt_clr with stall=1 -> 0.
REQ-039 Reset: drive reset low while 3 valid entries and stall=1 -> fwd_sel=0, stall=0, stall_cnt=0 before next edge.
